// File: rtl/eth_top_pkg.sv
// rtl/eth_top_pkg.sv - shared Ethernet RX filter constants and state type
package eth_top_pkg;

  localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam int          ETH_MCAST_BIT  = 40;

  typedef enum logic [1:0] {
    FILT_IDLE = 2'd0,
    FILT_PASS = 2'd1,
    FILT_DROP = 2'd2
  } filt_state_e;

endpackage

// File: rtl/eth_rx_addr_match.sv
// rtl/eth_rx_addr_match.sv - combinational destination MAC accept decision
module eth_rx_addr_match
  import eth_top_pkg::*;
(
  input  logic [47:0] dest,
  input  logic [47:0] mac_addr_i,
  input  logic        promisc_i,
  output logic        accept
);

  logic w_unicast_hit;
  logic w_bcast_hit;
  logic w_mcast_hit;

  assign w_unicast_hit = (dest == mac_addr_i);
  assign w_bcast_hit   = (dest == ETH_BCAST_ADDR);
  assign w_mcast_hit   = dest[ETH_MCAST_BIT];

  // Any single match, or promiscuous mode, lets the frame through
  always_comb begin
    accept = w_unicast_hit | w_bcast_hit | w_mcast_hit | promisc_i;
  end

endmodule

// File: rtl/eth_rx_addr_filter.sv
// rtl/eth_rx_addr_filter.sv - per-frame destination MAC filter; ETH_RX_FILT_STATS_EN adds frame counters
module eth_rx_addr_filter
  import eth_top_pkg::*;
#(
  parameter int USER_WIDTH = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [63:0]           s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic [USER_WIDTH-1:0] s_tuser,
  output logic [63:0]           m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [USER_WIDTH-1:0] m_tuser,
  input  logic [47:0]           mac_addr_i,
  input  logic                  promisc_i,
  output logic [CNT_WIDTH-1:0]  stat_pass_o,
  output logic [CNT_WIDTH-1:0]  stat_drop_o
);

  filt_state_e           r_state;
  filt_state_e           w_state_nxt;
  logic                  w_accept;
  logic                  w_out_ready;
  logic                  w_s_tready;
  logic                  w_hs;
  logic                  w_fwd;
  logic                  r_m_tvalid;
  logic [63:0]           r_m_tdata;
  logic                  r_m_tlast;
  logic [USER_WIDTH-1:0] r_m_tuser;

  // Decision is only consumed in IDLE, so config changes mid-frame have no effect
  eth_rx_addr_match u_match (
    .dest       (s_tdata[47:0]),
    .mac_addr_i (mac_addr_i),
    .promisc_i  (promisc_i),
    .accept     (w_accept)
  );

  // Output register can take a new beat when empty or draining this cycle
  assign w_out_ready = !r_m_tvalid || m_tready;
  assign w_hs        = s_tvalid && w_s_tready;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= FILT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a single-beat frame never leaves IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILT_IDLE: begin
        if (w_hs && !s_tlast) begin
          w_state_nxt = w_accept ? FILT_PASS : FILT_DROP;
        end
      end
      FILT_PASS, FILT_DROP: begin
        if (w_hs && s_tlast) begin
          w_state_nxt = FILT_IDLE;
        end
      end
      default: w_state_nxt = FILT_IDLE;
    endcase
  end

  // Outputs: forwarded beats wait for output space, discarded beats are always taken
  always_comb begin
    w_s_tready = 1'b0;
    w_fwd      = 1'b0;
    case (r_state)
      FILT_IDLE: begin
        w_s_tready = w_accept ? w_out_ready : 1'b1;
        w_fwd      = s_tvalid && w_accept && w_out_ready;
      end
      FILT_PASS: begin
        w_s_tready = w_out_ready;
        w_fwd      = s_tvalid && w_out_ready;
      end
      FILT_DROP: begin
        w_s_tready = 1'b1;
      end
      default: begin
        w_s_tready = 1'b0;
      end
    endcase
  end

  // One-entry output register; contents frozen while stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= '0;
    end else if (w_fwd) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_tdata;
      r_m_tlast  <= s_tlast;
      r_m_tuser  <= s_tuser;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_tready = w_s_tready;
  assign m_tvalid = r_m_tvalid;
  assign m_tdata  = r_m_tdata;
  assign m_tlast  = r_m_tlast;
  assign m_tuser  = r_m_tuser;

`ifdef ETH_RX_FILT_STATS_EN
  logic                 w_first_hs;
  logic [CNT_WIDTH-1:0] r_stat_pass;
  logic [CNT_WIDTH-1:0] r_stat_drop;

  assign w_first_hs = w_hs && (r_state == FILT_IDLE);

  // Count each frame once at its first-beat handshake, saturating at all-ones
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_pass <= '0;
      r_stat_drop <= '0;
    end else if (w_first_hs) begin
      if (w_accept) begin
        if (r_stat_pass != '1) r_stat_pass <= r_stat_pass + 1'b1;
      end else begin
        if (r_stat_drop != '1) r_stat_drop <= r_stat_drop + 1'b1;
      end
    end
  end

  assign stat_pass_o = r_stat_pass;
  assign stat_drop_o = r_stat_drop;
`else
  assign stat_pass_o = '0;
  assign stat_drop_o = '0;
`endif

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// tb/tb_eth_rx_addr_filter.sv - scoreboard bench for eth_rx_addr_filter
module tb_eth_rx_addr_filter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [0:0]  s_tuser;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [0:0]  m_tuser;
  logic [47:0] mac_addr_i;
  logic        promisc_i;
  logic [31:0] stat_pass_o;
  logic [31:0] stat_drop_o;

  eth_rx_addr_filter #(.USER_WIDTH(1), .CNT_WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tuser     (s_tuser),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .mac_addr_i  (mac_addr_i),
    .promisc_i   (promisc_i),
    .stat_pass_o (stat_pass_o),
    .stat_drop_o (stat_drop_o)
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [0:0]  u;
    int          hs_cyc;
  } beat_t;

  beat_t       sb[$];
  beat_t       mb;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          mdl_pass = 0;
  int          mdl_drop = 0;
  bit          rdy_mode = 1'b1;
  bit          lat_mode = 1'b1;
  int          stall = 0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_d;
  logic        prev_l;
  logic [0:0]  prev_u;

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Downstream ready: always-on or random stalls of 0..50 cycles
  always @(posedge clk_i) begin
    #1;
    if (rdy_mode) begin
      m_tready = 1'b1;
    end else if (stall > 0) begin
      m_tready = 1'b0;
      stall--;
    end else begin
      m_tready = 1'b1;
      if ($urandom_range(0, 7) == 0) stall = $urandom_range(0, 50);
    end
  end

  // Monitor: pops scoreboard on each output handshake and checks stall stability
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stable_valid", m_tvalid, 1);
        chk("stable_data", m_tdata, prev_d);
        chk("stable_last_user", {m_tlast, m_tuser}, {prev_l, prev_u});
      end
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          mb = sb.pop_front();
          chk("out_data", m_tdata, mb.d);
          chk("out_last", m_tlast, mb.l);
          chk("out_user", m_tuser, mb.u);
          if (lat_mode) chk("latency_cycle", cyc, mb.hs_cyc);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
      prev_u = m_tuser;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic l, input logic [0:0] u,
                           input bit chk_drop, output bit hs);
    int n = 0;
    s_tdata = d;
    s_tlast = l;
    s_tuser = u;
    s_tvalid = 1'b1;
    hs = 1'b0;
    while (!hs && n < 500) begin
      @(negedge clk_i);
      if (chk_drop) begin
        chk("drop_tready", s_tready, 1);
        chk("drop_mvalid", m_tvalid, 0);
      end
      hs = s_tready;
      n++;
      @(posedge clk_i);
      #1;
    end
    s_tvalid = 1'b0;
    if (!hs) chk("tready_timeout", 0, 1);
  endtask

  // Reference: whole-frame accept decision taken from config at the first beat
  task automatic send_frame(input logic [47:0] dest, input int nb, input int abort_after,
                            input int gap_max, input bit churn, input bit chk_drop);
    bit          acc;
    bit          hs;
    logic [63:0] d;
    logic [0:0]  u;
    beat_t       b;
    acc = (dest == mac_addr_i) || (dest == {48{1'b1}}) || dest[40] || promisc_i;
    if (acc) mdl_pass++;
    else mdl_drop++;
    for (int i = 0; i < nb; i++) begin
      d = (i == 0) ? {16'h1032, dest} : {$urandom(), $urandom()};
      u = 1'($urandom_range(0, 1));
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk_i);
        #1;
      end
      send_beat(d, (i == nb - 1), u, chk_drop && !acc, hs);
      if (!hs) return;
      if (acc && !(i == abort_after - 1 && abort_after < nb)) begin
        b.d = d;
        b.l = (i == nb - 1);
        b.u = u;
        b.hs_cyc = cyc;
        sb.push_back(b);
      end
      if (churn) begin
        mac_addr_i = {$urandom(), $urandom()} & ~(48'd1 << 40);
        promisc_i = ($urandom_range(0, 3) == 0);
      end
      if (i == abort_after - 1) return;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || m_tvalid) && n < 5000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic check_stats(input string tag);
`ifdef ETH_RX_FILT_STATS_EN
    chk({tag, "_stat_pass"}, stat_pass_o, mdl_pass);
    chk({tag, "_stat_drop"}, stat_drop_o, mdl_drop);
`else
    chk({tag, "_stat_pass"}, stat_pass_o, 0);
    chk({tag, "_stat_drop"}, stat_drop_o, 0);
`endif
  endtask

  function automatic logic [47:0] rand_dest();
    logic [47:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0: r = mac_addr_i;
      1: r = 48'hFFFF_FFFF_FFFF;
      2: r = r | (48'd1 << 40);
      default: begin
        r = r & ~(48'd1 << 40);
        if (r == mac_addr_i) r = r ^ 48'd1;
      end
    endcase
    return r;
  endfunction

  initial begin
    rst_i = 1'b1;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tlast = 1'b0;
    s_tuser = '0;
    m_tready = 1'b1;
    mac_addr_i = 48'h2070_9800_1032;
    promisc_i = 1'b0;
    #1;
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_mdata", m_tdata, 0);
    chk("rst_mlast_user", {m_tlast, m_tuser}, 0);
    check_stats("rst");
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    send_frame(48'h2070_9800_1032, 8, 8, 0, 0, 0);
    drain();
    check_stats("own_mac");

    send_frame(48'hFFFF_FFFF_FFFF, 8, 8, 0, 0, 0);
    send_frame(48'h0100_5EFF_FFFF, 8, 8, 0, 0, 0);
    drain();
    check_stats("bcast_mcast");

    send_frame(48'h0001_5EFF_3FFF, 8, 8, 0, 0, 1);
    drain();
    check_stats("reject");
    promisc_i = 1'b1;
    send_frame(48'h0001_5EFF_3FFF, 8, 8, 0, 0, 0);
    drain();
    promisc_i = 1'b0;
    check_stats("promisc");

    send_frame(48'hFFFF_FFFF_FFFF, 1, 1, 0, 0, 0);
    send_frame(48'h0001_5EFF_3FFF, 1, 1, 0, 0, 0);
    send_frame(48'h2070_9800_1032, 3, 3, 0, 0, 0);
    drain();
    check_stats("single_beat");

    send_frame(48'h2070_9800_1032, 8, 4, 0, 0, 0);
    chk("pre_rst_mvalid", m_tvalid, 1);
    rst_i = 1'b1;
    #1;
    chk("midrst_mvalid", m_tvalid, 0);
    chk("midrst_mdata", m_tdata, 0);
    chk("midrst_sb_empty", sb.size(), 0);
    mdl_pass = 0;
    mdl_drop = 0;
    check_stats("midrst");
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    send_frame(48'h0001_5EFF_3FFF, 4, 4, 0, 0, 1);
    send_frame(48'h2070_9800_1032, 4, 4, 0, 0, 0);
    drain();
    check_stats("post_rst");

    rdy_mode = 1'b0;
    lat_mode = 1'b0;
    for (int f = 0; f < 40; f++) begin
      send_frame(rand_dest(), $urandom_range(1, 8), 8, 3, 1, 0);
    end
    rdy_mode = 1'b1;
    drain();
    check_stats("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
